// File: rtl/pwm_pkg.sv
// Shared types for the PWM preconditioner: datapath width, FSM states and the rise/fall edge pair.
package pwm_pkg;

  localparam int WIDTH = 13;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_SYNC
  } precond_state_t;

  typedef struct packed {
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
  } edge_t;

endpackage

// File: rtl/pwm_preconditioner_if.sv
// Bus between the period/duty source and the preconditioner; duty_max exists only with PWM_PRECOND_DUTY_LIMIT_EN.
interface pwm_preconditioner_if #(
  parameter int WIDTH = pwm_pkg::WIDTH,
  parameter int DEPTH = 249
);
  logic [WIDTH-1:0]            cycle;
  logic [WIDTH-1:0]            time_cnt;
  logic                        start;
  logic [DEPTH-1:0][WIDTH-1:0] duty;
  logic [DEPTH-1:0][WIDTH-1:0] phase;
`ifdef PWM_PRECOND_DUTY_LIMIT_EN
  logic [WIDTH-1:0]            duty_max;
`endif
  logic                        busy;
  logic                        done;
  logic [DEPTH-1:0][WIDTH-1:0] rise;
  logic [DEPTH-1:0][WIDTH-1:0] fall;

`ifdef PWM_PRECOND_DUTY_LIMIT_EN
  modport master (output cycle, time_cnt, start, duty, phase, duty_max,
                  input  busy, done, rise, fall);
  modport slave  (input  cycle, time_cnt, start, duty, phase, duty_max,
                  output busy, done, rise, fall);
`else
  modport master (output cycle, time_cnt, start, duty, phase,
                  input  busy, done, rise, fall);
  modport slave  (input  cycle, time_cnt, start, duty, phase,
                  output busy, done, rise, fall);
`endif
endinterface

// File: rtl/pwm_precond_calc.sv
// Two-stage registered (duty, phase) -> (rise, fall) converter for one channel per clock.
// PWM_PRECOND_DUTY_LIMIT_EN adds a duty_max clip ahead of the full-on check.
module pwm_precond_calc
  import pwm_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [WIDTH-1:0] duty,
  input  logic [WIDTH-1:0] phase,
  input  logic [WIDTH-1:0] cycle,
`ifdef PWM_PRECOND_DUTY_LIMIT_EN
  input  logic [WIDTH-1:0] duty_max,
`endif
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx,
  output edge_t            out_edge
);

  logic [WIDTH-1:0] duty_eff;
  logic             s1_vld;
  logic [IDX_W-1:0] s1_idx;
  logic             s1_full;
  logic [WIDTH-1:0] s1_lo;
  logic [WIDTH-1:0] s1_hi;
  logic [WIDTH-1:0] s1_phase;

  logic [WIDTH:0]   c_x, p_x, lo_x, sum_x, rise_x, fall_x;

  always_comb begin
    duty_eff = duty;
`ifdef PWM_PRECOND_DUTY_LIMIT_EN
    if (duty > duty_max) duty_eff = duty_max;
`endif
  end

  // Centre the pulse on phase: lo ticks before, the ceiling half after.
  assign c_x    = {1'b0, cycle};
  assign p_x    = {1'b0, s1_phase};
  assign lo_x   = {1'b0, s1_lo};
  assign sum_x  = p_x + {1'b0, s1_hi};
  assign rise_x = (p_x >= lo_x) ? (p_x - lo_x) : (p_x + c_x - lo_x);
  assign fall_x = (sum_x < c_x) ? sum_x : (sum_x - c_x);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_idx   <= '0;
      s1_full  <= 1'b0;
      s1_lo    <= '0;
      s1_hi    <= '0;
      s1_phase <= '0;
      out_vld  <= 1'b0;
      out_idx  <= '0;
      out_edge <= '0;
    end else begin
      s1_vld   <= in_vld;
      s1_idx   <= in_idx;
      s1_full  <= (duty_eff >= cycle);
      s1_lo    <= duty_eff >> 1;
      s1_hi    <= duty_eff - (duty_eff >> 1);
      s1_phase <= phase;

      out_vld  <= s1_vld;
      out_idx  <= s1_idx;
      if (s1_full) begin
        out_edge.rise <= '0;
        out_edge.fall <= cycle;
      end else begin
        out_edge.rise <= rise_x[WIDTH-1:0];
        out_edge.fall <= fall_x[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/pwm_preconditioner.sv
// Serially converts all channels into a shadow bank, then commits it to rise/fall on the PWM period boundary.
// PWM_PRECOND_DUTY_LIMIT_EN enables the sampled duty_max clip.
module pwm_preconditioner
  import pwm_pkg::*;
#(
  parameter int DEPTH = 249
) (
  input  logic                 clk,
  input  logic                 rst,
  pwm_preconditioner_if.slave  bus
);

  localparam int               IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(DEPTH - 1);

  precond_state_t              state;
  logic [IDX_W-1:0]            ch;
  logic                        feed;
  logic [DEPTH-1:0][WIDTH-1:0] duty_q, phase_q;
  logic [WIDTH-1:0]            cycle_q;
`ifdef PWM_PRECOND_DUTY_LIMIT_EN
  logic [WIDTH-1:0]            duty_max_q;
`endif
  edge_t                       shadow_q [DEPTH];
  logic [DEPTH-1:0][WIDTH-1:0] rise_q, fall_q;
  logic                        busy_q, done_q;

  logic                        out_vld;
  logic [IDX_W-1:0]            out_idx;
  edge_t                       out_edge;
  logic                        boundary;

  assign boundary = (bus.time_cnt == cycle_q - 1'b1);

  pwm_precond_calc #(.IDX_W(IDX_W)) u_calc (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (feed),
    .in_idx   (ch),
    .duty     (duty_q[ch]),
    .phase    (phase_q[ch]),
    .cycle    (cycle_q),
`ifdef PWM_PRECOND_DUTY_LIMIT_EN
    .duty_max (duty_max_q),
`endif
    .out_vld  (out_vld),
    .out_idx  (out_idx),
    .out_edge (out_edge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= '0;
      feed    <= 1'b0;
      duty_q  <= '0;
      phase_q <= '0;
      cycle_q <= '0;
`ifdef PWM_PRECOND_DUTY_LIMIT_EN
      duty_max_q <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_vld) shadow_q[out_idx] <= out_edge;
      if (feed) begin
        ch <= ch + 1'b1;
        if (ch == LAST) feed <= 1'b0;
      end

      case (state)
        IDLE, WAIT_SYNC: begin
          // A restart from WAIT_SYNC simply overwrites every shadow entry before the next commit.
          if (bus.start) begin
            duty_q  <= bus.duty;
            phase_q <= bus.phase;
            cycle_q <= bus.cycle;
`ifdef PWM_PRECOND_DUTY_LIMIT_EN
            duty_max_q <= bus.duty_max;
`endif
            ch      <= '0;
            feed    <= 1'b1;
            busy_q  <= 1'b1;
            state   <= RUN;
          end else if (state == WAIT_SYNC && boundary) begin
            for (int i = 0; i < DEPTH; i++) begin
              rise_q[i] <= shadow_q[i].rise;
              fall_q[i] <= shadow_q[i].fall;
            end
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        RUN: begin
          if (out_vld && out_idx == LAST) state <= WAIT_SYNC;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Directed bench for pwm_preconditioner: DEPTH=4, CYCLE=4096, free-running period counter.
module tb_pwm_preconditioner;
  import pwm_pkg::*;

  localparam int D = 4;
  localparam int C = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;
  int   exp_r [D];
  int   exp_f [D];

  pwm_preconditioner_if #(.DEPTH(D)) bus ();

  pwm_preconditioner #(.DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial forever #5 clk = ~clk;

  // Counter advances 2 time units after each rising edge, so stimulus at negedge sees the next sampled value.
  initial begin
    bus.time_cnt = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.time_cnt = (int'(bus.time_cnt) >= C - 1) ? '0 : bus.time_cnt + 13'd1;
    end
  end

  task automatic set_ch(input int i, input int d, input int p, input int er, input int ef);
    bus.duty[i]  = 13'(d);
    bus.phase[i] = 13'(p);
    exp_r[i]     = er;
    exp_f[i]     = ef;
  endtask

  task automatic start_now();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 9000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < D; i++) begin
      n_run++;
      if (bus.rise[i] !== 13'd0 || bus.fall[i] !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_edges ch%0d: got %0d/%0d expected 0/0", i, bus.rise[i], bus.fall[i]);
      end
    end
    n_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%0b done=%0b expected 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_centre();
    int n;
    set_ch(0, 2048, 2048, 1024, 3072);
    set_ch(1, 2048, 0,    3072, 1024);
    set_ch(2, 0,    100,  100,  100);
    set_ch(3, 3,    10,   9,    12);
    @(negedge clk);
    start_now();
    wait_done(n);
    n_run++;
    if (n >= 9000) begin n_fail++; $display("FAIL centre_timeout: waited %0d expected <9000", n); end
    for (int i = 0; i < D; i++) begin
      n_run++;
      if (int'(bus.rise[i]) != exp_r[i] || int'(bus.fall[i]) != exp_f[i]) begin
        n_fail++;
        $display("FAIL centre ch%0d: got %0d/%0d expected %0d/%0d", i, bus.rise[i], bus.fall[i], exp_r[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_full_and_wrap();
    int n;
    set_ch(0, 4096, 5,    0,    4096);
    set_ch(1, 5000, 7,    0,    4096);
    set_ch(2, 1,    0,    0,    1);
    set_ch(3, 4,    4094, 4092, 0);
    @(negedge clk);
    start_now();
    wait_done(n);
    n_run++;
    if (n >= 9000) begin n_fail++; $display("FAIL full_timeout: waited %0d expected <9000", n); end
    for (int i = 0; i < D; i++) begin
      n_run++;
      if (int'(bus.rise[i]) != exp_r[i] || int'(bus.fall[i]) != exp_f[i]) begin
        n_fail++;
        $display("FAIL full_wrap ch%0d: got %0d/%0d expected %0d/%0d", i, bus.rise[i], bus.fall[i], exp_r[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_commit_timing();
    int n, k, changes, on_cnt, r, f;
    int duty_ref [2];
    set_ch(0, 1000, 500,  0,    1000);
    set_ch(1, 300,  4000, 3850, 54);
    set_ch(2, 0,    0,    0,    0);
    set_ch(3, 4096, 0,    0,    4096);
    duty_ref[0] = 1000;
    duty_ref[1] = 300;
    k = 0;
    @(negedge clk);
    while (int'(bus.time_cnt) != 100 && k < 5000) begin @(negedge clk); k++; end
    start_now();
    n_run++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %0b expected 1", bus.busy); end
    n = 0;
    changes = 0;
    while (bus.done !== 1'b1 && n < 9000) begin
      if (bus.rise[0] !== 13'd0 || bus.fall[0] !== 13'd4096) changes++;
      @(posedge clk);
      #1;
      n++;
    end
    n_run++;
    if (changes != 0) begin n_fail++; $display("FAIL hold_before_commit: got %0d changes expected 0", changes); end
    n_run++;
    if (n != 3995) begin n_fail++; $display("FAIL commit_latency: got %0d expected 3995", n); end
    n_run++;
    if (int'(bus.time_cnt) != C - 1) begin n_fail++; $display("FAIL commit_edge: got %0d expected 4095", bus.time_cnt); end
    for (int i = 0; i < D; i++) begin
      n_run++;
      if (int'(bus.rise[i]) != exp_r[i] || int'(bus.fall[i]) != exp_f[i]) begin
        n_fail++;
        $display("FAIL commit_vals ch%0d: got %0d/%0d expected %0d/%0d", i, bus.rise[i], bus.fall[i], exp_r[i], exp_f[i]);
      end
    end
    // Reference generator rule over the next period: high in [rise,fall), wrapping when fall<rise.
    for (int c = 0; c < 2; c++) begin
      on_cnt = 0;
      r = int'(bus.rise[c]);
      f = int'(bus.fall[c]);
      for (int t = 0; t < C; t++)
        if ((r <= f) ? (t >= r && t < f) : (t >= r || t < f)) on_cnt++;
      n_run++;
      if (on_cnt != duty_ref[c]) begin
        n_fail++;
        $display("FAIL on_time ch%0d: got %0d expected %0d", c, on_cnt, duty_ref[c]);
      end
    end
    @(posedge clk);
    #1;
    n_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_single: done=%0b busy=%0b expected 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_deferred_and_restart();
    int n, m, k;
    set_ch(0, 2, 2, 1, 3);
    set_ch(1, 0, 0, 0, 0);
    set_ch(2, 0, 0, 0, 0);
    set_ch(3, 0, 0, 0, 0);
    k = 0;
    @(negedge clk);
    while (int'(bus.time_cnt) != 4093 && k < 5000) begin @(negedge clk); k++; end
    start_now();
    n = 1;
    @(posedge clk);
    #1;
    n++;
    bus.duty[0]  = 13'd10;
    bus.phase[0] = 13'd20;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    n++;
    bus.start = 1'b0;
    wait_done(m);
    n_run++;
    if (n - 1 + m != 4098) begin n_fail++; $display("FAIL deferred_latency: got %0d expected 4098", n - 1 + m); end
    n_run++;
    if (bus.rise[0] !== 13'd1 || bus.fall[0] !== 13'd3) begin
      n_fail++;
      $display("FAIL ignore_start_in_run: got %0d/%0d expected 1/3", bus.rise[0], bus.fall[0]);
    end
    set_ch(0, 100, 1000, 950, 1050);
    @(negedge clk);
    start_now();
    repeat (20) begin @(posedge clk); #1; end
    n_run++;
    if (bus.busy !== 1'b1 || bus.rise[0] !== 13'd1 || bus.fall[0] !== 13'd3) begin
      n_fail++;
      $display("FAIL wait_sync_hold: busy=%0b edges %0d/%0d expected 1 and 1/3", bus.busy, bus.rise[0], bus.fall[0]);
    end
    set_ch(0, 200, 1000, 900, 1100);
    @(negedge clk);
    start_now();
    wait_done(n);
    n_run++;
    if (n != 4074) begin n_fail++; $display("FAIL restart_latency: got %0d expected 4074", n); end
    n_run++;
    if (int'(bus.rise[0]) != exp_r[0] || int'(bus.fall[0]) != exp_f[0]) begin
      n_fail++;
      $display("FAIL restart_vals: got %0d/%0d expected %0d/%0d", bus.rise[0], bus.fall[0], exp_r[0], exp_f[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int n, done_cnt;
    set_ch(0, 2048, 1024, 0,    2048);
    set_ch(1, 4095, 0,    2049, 2048);
    set_ch(2, 0,    0,    0,    0);
    set_ch(3, 0,    0,    0,    0);
    @(negedge clk);
    start_now();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < D; i++) begin
      n_run++;
      if (bus.rise[i] !== 13'd0 || bus.fall[i] !== 13'd0) begin
        n_fail++;
        $display("FAIL midrun_reset ch%0d: got %0d/%0d expected 0/0", i, bus.rise[i], bus.fall[i]);
      end
    end
    n_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset_flags: busy=%0b done=%0b expected 0/0", bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (4200) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    n_run++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL lost_commit: got %0d done pulses expected 0", done_cnt); end
    @(negedge clk);
    start_now();
    wait_done(n);
    for (int i = 0; i < D; i++) begin
      n_run++;
      if (int'(bus.rise[i]) != exp_r[i] || int'(bus.fall[i]) != exp_f[i]) begin
        n_fail++;
        $display("FAIL after_reset ch%0d: got %0d/%0d expected %0d/%0d", i, bus.rise[i], bus.fall[i], exp_r[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_duty_limit();
    int n;
`ifdef PWM_PRECOND_DUTY_LIMIT_EN
    bus.duty_max = 13'd1000;
    set_ch(0, 3000, 2048, 1548, 2548);
`else
    set_ch(0, 3000, 2048, 548, 3548);
`endif
    @(negedge clk);
    start_now();
    wait_done(n);
    n_run++;
    if (int'(bus.rise[0]) != exp_r[0] || int'(bus.fall[0]) != exp_f[0]) begin
      n_fail++;
      $display("FAIL duty_limit: got %0d/%0d expected %0d/%0d", bus.rise[0], bus.fall[0], exp_r[0], exp_f[0]);
    end
  endtask

  initial begin
    bus.cycle = 13'(C);
    bus.start = 1'b0;
    bus.duty  = '0;
    bus.phase = '0;
`ifdef PWM_PRECOND_DUTY_LIMIT_EN
    bus.duty_max = 13'd8191;
`endif
    test_reset();
    test_centre();
    test_full_and_wrap();
    test_commit_timing();
    test_deferred_and_restart();
    test_reset_mid_run();
    test_duty_limit();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
